// File: rtl/sipo_framed.sv
// Serial-in parallel-out deserialiser: collects WIDTH qualified bits into a word and
// presents it on a valid/ready output, with one word of buffering behind the output register.
module sipo_framed #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             enable,
  output logic             sin_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] sreg_reg;
  logic [WIDTH-1:0] sreg_next;
  logic             accept;
  logic             handshake;
  logic             out_free;

  assign sin_ready = (state_reg == COLLECT);
  assign accept    = enable && sin_ready;
  assign handshake = pout_valid && pout_ready;
  assign out_free  = !pout_valid || handshake;

  generate
    if (MSB_FIRST) begin : g_msb
      assign sreg_next = {sreg_reg[WIDTH-2:0], sin};
    end else begin : g_lsb
      assign sreg_next = {sin, sreg_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= COLLECT;
      sreg_reg   <= '0;
      pout       <= '0;
      pout_valid <= 1'b0;
      bit_cnt    <= '0;
      overrun    <= 1'b0;
    end else begin
      // Consumption empties the output unless a new word is loaded below.
      if (handshake) begin
        pout_valid <= 1'b0;
      end

      if (clear) begin
        state_reg <= COLLECT;
        sreg_reg  <= '0;
        bit_cnt   <= '0;
        overrun   <= 1'b0;
      end else begin
        if (enable && !sin_ready) begin
          overrun <= 1'b1;
        end
        case (state_reg)
          COLLECT: begin
            if (accept) begin
              sreg_reg <= sreg_next;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                if (out_free) begin
                  pout       <= sreg_next;
                  pout_valid <= 1'b1;
                end else begin
                  state_reg <= FULL;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          FULL: begin
            if (handshake) begin
              pout       <= sreg_reg;
              pout_valid <= 1'b1;
              state_reg  <= COLLECT;
            end
          end
          default: state_reg <= COLLECT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_framed.sv
// Directed bench for sipo_framed: an MSB-first and an LSB-first instance share one stimulus.
module tb_sipo_framed;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       pout_ready = 1'b0;

  logic       sin_ready, pout_valid, overrun;
  logic [7:0] pout;
  logic [2:0] bit_cnt;
  logic       l_sin_ready, l_pout_valid, l_overrun;
  logic [7:0] l_pout;
  logic [2:0] l_bit_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_framed #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .sin(sin), .enable(enable), .sin_ready(sin_ready),
    .clear(clear), .pout(pout), .pout_valid(pout_valid), .pout_ready(pout_ready),
    .bit_cnt(bit_cnt), .overrun(overrun)
  );

  sipo_framed #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .sin(sin), .enable(enable), .sin_ready(l_sin_ready),
    .clear(clear), .pout(l_pout), .pout_valid(l_pout_valid), .pout_ready(pout_ready),
    .bit_cnt(l_bit_cnt), .overrun(l_overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Sends the top n bits of v, most significant first, on consecutive cycles.
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sin    = v[7-i];
      enable = 1'b1;
      step();
    end
    enable = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
    $display("frame %02h sent: pout=%02h pout_valid=%0b sin_ready=%0b", v, pout, pout_valid, sin_ready);
  endtask

  initial begin
    int gap;

    // 1: reset
    rst = 1'b1;
    step();
    step();
    chk("rst_pout", pout, 8'h00);
    chk("rst_valid", pout_valid, 1'b0);
    chk("rst_sin_ready", sin_ready, 1'b1);
    chk("rst_bit_cnt", bit_cnt, 3'd0);
    chk("rst_overrun", overrun, 1'b0);
    rst = 1'b0;

    // 2/3: word B4 on consecutive cycles, both bit orders
    pout_ready = 1'b1;
    send_bits(8'hB4, 7);
    chk("b4_cnt7", bit_cnt, 3'd7);
    chk("b4_not_valid_yet", pout_valid, 1'b0);
    sin = 1'b0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk("b4_valid", pout_valid, 1'b1);
    chk("b4_pout", pout, 8'hB4);
    chk("b4_lsb_pout", l_pout, 8'h2D);
    chk("b4_cnt0", bit_cnt, 3'd0);
    step();
    chk("b4_valid_one_cycle", pout_valid, 1'b0);
    chk("b4_pout_held", pout, 8'hB4);

    // 3: word 4B with idle gaps; bit_cnt must hold in gaps
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h4B;
      sin = w[7-i];
      enable = 1'b1;
      step();
      enable = 1'b0;
      if (i < 7) begin
        gap = $urandom_range(1, 5);
        for (int g = 0; g < gap; g++) step();
        chk("gap_cnt_hold", bit_cnt, i + 1);
      end
    end
    chk("gap_valid", pout_valid, 1'b1);
    chk("gap_pout", pout, 8'h4B);
    chk("gap_lsb_pout", l_pout, 8'hD2);
    step();
    chk("gap_consumed", pout_valid, 1'b0);

    // 4: backpressure, FULL, overrun
    pout_ready = 1'b0;
    send_byte(8'h11);
    chk("bp_pout11", pout, 8'h11);
    chk("bp_valid11", pout_valid, 1'b1);
    send_byte(8'h22);
    chk("bp_full_ready", sin_ready, 1'b0);
    chk("bp_full_pout", pout, 8'h11);
    chk("bp_full_cnt", bit_cnt, 3'd0);
    chk("bp_no_overrun", overrun, 1'b0);
    sin = 1'b1;
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk("bp_overrun", overrun, 1'b1);
    chk("bp_dropped_cnt", bit_cnt, 3'd0);
    pout_ready = 1'b1;
    step();
    chk("bp_pout22", pout, 8'h22);
    chk("bp_valid22", pout_valid, 1'b1);
    chk("bp_ready_again", sin_ready, 1'b1);
    step();
    chk("bp_22_consumed", pout_valid, 1'b0);

    // 5: last bit of 33 coincides with the handshake of 11
    pout_ready = 1'b0;
    send_byte(8'h11);
    send_bits(8'h33, 7);
    chk("nb_hold11", pout, 8'h11);
    chk("nb_valid_hold", pout_valid, 1'b1);
    sin = 1'b1;
    enable = 1'b1;
    pout_ready = 1'b1;
    step();
    enable = 1'b0;
    chk("nb_pout33", pout, 8'h33);
    chk("nb_no_bubble", pout_valid, 1'b1);
    chk("nb_ready", sin_ready, 1'b1);
    step();
    chk("nb_consumed", pout_valid, 1'b0);
    chk("nb_held33", pout, 8'h33);
    chk("overrun_sticky", overrun, 1'b1);

    // 6: clear mid-frame, with a bit offered in the clear cycle
    send_bits(8'hE0, 3);
    chk("clr_cnt3", bit_cnt, 3'd3);
    clear = 1'b1;
    enable = 1'b1;
    sin = 1'b1;
    step();
    clear = 1'b0;
    enable = 1'b0;
    chk("clr_cnt0", bit_cnt, 3'd0);
    chk("clr_overrun0", overrun, 1'b0);
    send_byte(8'hC3);
    chk("clr_clean_pout", pout, 8'hC3);
    chk("clr_clean_valid", pout_valid, 1'b1);

    // reset while a word is pending and a frame is partly collected
    pout_ready = 1'b0;
    send_bits(8'hA8, 5);
    chk("mid_cnt5", bit_cnt, 3'd5);
    chk("mid_valid", pout_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_pout", pout, 8'h00);
    chk("mid_rst_valid", pout_valid, 1'b0);
    chk("mid_rst_cnt", bit_cnt, 3'd0);
    chk("mid_rst_ready", sin_ready, 1'b1);
    chk("mid_rst_overrun", overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
